// File: rtl/rv_stream_demux_pkg.sv
// Shared constants for the stream demultiplexer: select-width derivation,
// per-output buffer depth and occupancy counter width.
package rv_stream_demux_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    // Width of a select index for n destinations; a single output still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_elastic_buffer_2.sv
// Two-entry FIFO used as the per-output elastic buffer of rv_stream_demux.
// A push into a full buffer or a pop from an empty one is ignored.
module rv_elastic_buffer_2
    import rv_stream_demux_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DATAW-1:0] mem_reg [FIFO_DEPTH];
    logic             head_reg;
    logic             tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                mem_reg[tail_reg] <= data_in;
                tail_reg          <= ~tail_reg;
            end
            if (do_pop) begin
                head_reg <= ~head_reg;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign data  = mem_reg[head_reg];
    assign count = count_reg;

endmodule

// File: rtl/rv_stream_demux.sv
// Routes one valid/ready stream to one of NUM_OUTS buffered outputs chosen by
// sel_in; out-of-range selects are accepted, discarded and flagged on drop_err.
module rv_stream_demux
    import rv_stream_demux_pkg::*;
#(
    parameter int NUM_OUTS = 4,
    parameter int DATAW    = 32,
    parameter int SELW     = sel_width(NUM_OUTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [DATAW-1:0]          data_in,
    input  logic [SELW-1:0]           sel_in,
    output logic [NUM_OUTS-1:0]       valid_out,
    input  logic [NUM_OUTS-1:0]       ready_out,
    output logic [NUM_OUTS*DATAW-1:0] data_out,
    output logic                      drop_err
);

    logic [NUM_OUTS-1:0] full;
    logic [NUM_OUTS-1:0] empty;
    logic [NUM_OUTS-1:0] push;
    logic [NUM_OUTS-1:0] pop;
    logic [CNT_W-1:0]    count [NUM_OUTS];
    logic                in_range;
    logic                full_sel;
    logic                accept;
    logic                drop_err_reg;

    assign in_range = (NUM_OUTS == 1) || ({1'b0, sel_in} < (SELW+1)'(NUM_OUTS));

    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            if ((NUM_OUTS == 1) || (sel_in == SELW'(i))) begin
                full_sel = full[i];
            end
        end
    end

    // Ready looks only at the selected buffer's occupancy, never at ready_out.
    assign ready_in = reset && !(in_range && full_sel);
    assign accept   = valid_in && ready_in;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTS; gi++) begin : g_out
            assign push[gi]      = accept && ((NUM_OUTS == 1) || (sel_in == SELW'(gi)));
            assign pop[gi]       = ready_out[gi] && !empty[gi];
            assign valid_out[gi] = (count[gi] != '0);

            rv_elastic_buffer_2 #(
                .DATAW (DATAW)
            ) u_buf (
                .clk     (clk),
                .reset   (reset),
                .push    (push[gi]),
                .pop     (pop[gi]),
                .data_in (data_in),
                .data    (data_out[gi*DATAW +: DATAW]),
                .count   (count[gi]),
                .full    (full[gi]),
                .empty   (empty[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_err_reg <= 1'b0;
        end else begin
            drop_err_reg <= accept && !in_range;
        end
    end

    assign drop_err = drop_err_reg;

endmodule

// File: tb/tb_rv_stream_demux.sv
// Bench for rv_stream_demux: a 4-output and a 3-output instance share stimulus
// and are checked each cycle against per-output queue models.
module tb_rv_stream_demux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in;
    logic [1:0]   sel_in;
    logic [31:0]  data_in;
    logic [3:0]   ready_out;

    logic         ready_a;
    logic [3:0]   valid_a;
    logic [127:0] data_a;
    logic         drop_a;

    logic         ready_b;
    logic [2:0]   valid_b;
    logic [95:0]  data_b;
    logic         drop_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] qa [4][$];
    logic [31:0] qb [3][$];
    logic        exp_drop_b = 1'b0;

    always #5 clk = ~clk;

    rv_stream_demux #(.NUM_OUTS(4), .DATAW(32)) dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_a),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .valid_out (valid_a),
        .ready_out (ready_out),
        .data_out  (data_a),
        .drop_err  (drop_a)
    );

    rv_stream_demux #(.NUM_OUTS(3), .DATAW(32)) dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_b),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .valid_out (valid_b),
        .ready_out (ready_out[2:0]),
        .data_out  (data_b),
        .drop_err  (drop_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every output against the queue models (called away from the clock edge).
    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("valid_a%0d", i), 32'(valid_a[i]), 32'(qa[i].size() > 0));
            if (qa[i].size() > 0) check($sformatf("data_a%0d", i), data_a[i*32 +: 32], qa[i][0]);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("valid_b%0d", i), 32'(valid_b[i]), 32'(qb[i].size() > 0));
            if (qb[i].size() > 0) check($sformatf("data_b%0d", i), data_b[i*32 +: 32], qb[i][0]);
        end
        check("drop_a", 32'(drop_a), 32'd0);
        check("drop_b", 32'(drop_b), 32'(exp_drop_b));
    endtask

    // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] r, output logic acc);
        logic exp_rdy_a;
        logic exp_rdy_b;
        valid_in  = v;
        sel_in    = s;
        data_in   = d;
        ready_out = r;
        #1;
        exp_rdy_a = (qa[s].size() < 2);
        if (s == 2'd3) exp_rdy_b = 1'b1;
        else           exp_rdy_b = (qb[s].size() < 2);
        check("ready_a", 32'(ready_a), 32'(exp_rdy_a));
        check("ready_b", 32'(ready_b), 32'(exp_rdy_b));
        acc = v && ready_a;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (r[i] && qa[i].size() > 0) void'(qa[i].pop_front());
        for (int i = 0; i < 3; i++) if (r[i] && qb[i].size() > 0) void'(qb[i].pop_front());
        if (v && exp_rdy_a) qa[s].push_back(d);
        if (v && exp_rdy_b && s != 2'd3) qb[s].push_back(d);
        exp_drop_b = v && (s == 2'd3);
        @(negedge clk);
        $display("step v=%0d sel=%0d data=%h rdy_out=%b acc=%0d", v, s, d, r, acc);
        check_outputs();
    endtask

    // Reset asserted at a negedge: outputs must clear immediately.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        check("rst_data_a_lo", data_a[31:0], 32'd0);
        check("rst_data_a_hi", data_a[95:64], 32'd0);
        check("rst_data_b", data_b[31:0] | data_b[63:32] | data_b[95:64], 32'd0);
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_drop_b", 32'(drop_b), 32'd0);
        for (int i = 0; i < 4; i++) qa[i].delete();
        for (int i = 0; i < 3; i++) qb[i].delete();
        exp_drop_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset applied and released");
    endtask

    initial begin
        logic acc;
        int   tries;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        sel_in    = '0;
        data_in   = '0;
        ready_out = '0;
        @(negedge clk);
        apply_reset();

        // Three words to output 2 with all consumers ready.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd2, 32'h200 + 32'(k), 4'b1111, acc);
            check("t1_accept", 32'(acc), 32'd1);
        end
        step(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Output 1 stalled: third word must wait until its consumer drains.
        step(1'b1, 2'd1, 32'hA, 4'b1101, acc);
        check("t2_a_acc", 32'(acc), 32'd1);
        step(1'b1, 2'd1, 32'hB, 4'b1101, acc);
        check("t2_b_acc", 32'(acc), 32'd1);
        step(1'b1, 2'd1, 32'hC, 4'b1101, acc);
        check("t2_c_blocked", 32'(acc), 32'd0);
        step(1'b1, 2'd1, 32'hC, 4'b1101, acc);
        check("t2_c_blocked2", 32'(acc), 32'd0);

        // Still stalled: alternating sel=3 traffic keeps flowing.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, (k % 2 == 0) ? 2'd3 : 2'd1, 32'h300 + 32'(k), 4'b1101, acc);
            check("t3_acc", 32'(acc), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("t3_out1_head", data_a[63:32], 32'hA);

        // Consumer 1 rises; pop that cycle does not raise ready_in until the next.
        step(1'b1, 2'd1, 32'hC, 4'b1111, acc);
        check("t2_c_same_cycle", 32'(acc), 32'd0);
        step(1'b1, 2'd1, 32'hC, 4'b1111, acc);
        check("t2_c_next_cycle", 32'(acc), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Fill output 0, then pop and offer a word together.
        step(1'b1, 2'd0, 32'h50, 4'b1110, acc);
        step(1'b1, 2'd0, 32'h51, 4'b1110, acc);
        step(1'b1, 2'd0, 32'h52, 4'b1111, acc);
        check("t5_full_pop", 32'(acc), 32'd0);
        tries = 0;
        do begin
            step(1'b1, 2'd0, 32'h52, 4'b1111, acc);
            tries++;
        end while (!acc && tries < 10);
        check("t5_accept_later", 32'(acc), 32'd1);

        // Load outputs 0 and 2, then reset mid-stream.
        step(1'b1, 2'd0, 32'h60, 4'b0000, acc);
        step(1'b1, 2'd2, 32'h62, 4'b0000, acc);
        step(1'b1, 2'd3, 32'h63, 4'b0000, acc);
        apply_reset();
        step(1'b1, 2'd2, 32'h77, 4'b0000, acc);
        check("post_rst_acc", 32'(acc), 32'd1);
        check("post_rst_alone", 32'(valid_a), 32'b0100);
        step(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic       v;
            logic [3:0] r;
            v = ($urandom_range(0, 3) != 0);
            r = 4'($urandom) | 4'($urandom);
            step(v, 2'($urandom), $urandom, r, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
